// File: rtl/ticket_vend_if.sv
// Ticket vending controller bus: debounced pulse inputs, admin config
// and display/vend/change outputs, grouped for the core and its driver.
interface ticket_vend_if #(
  parameter int SEL_W    = 2,
  parameter int QTY_W    = 3,
  parameter int PRICE_W  = 4,
  parameter int STOCK_W  = 4,
  parameter int CREDIT_W = 6
);
  localparam int CFG_W = (PRICE_W > STOCK_W) ? PRICE_W : STOCK_W;

  logic                        coin5, coin10, coin20;
  logic [SEL_W-1:0]            sel;
  logic [QTY_W-1:0]            qty;
  logic                        buy, cancel, admin_req;
  logic [3:0]                  password;
  logic                        price_we, stock_we;
  logic [CFG_W-1:0]            cfg_data;

  logic [CREDIT_W-1:0]         credit;
  logic [PRICE_W+QTY_W-1:0]    cost;
  logic [PRICE_W-1:0]          price_rd;
  logic [STOCK_W-1:0]          stock_rd;
  logic                        vend_valid;
  logic [SEL_W-1:0]            vend_type;
  logic [QTY_W-1:0]            vend_qty;
  logic                        chg20, chg10, chg5;
  logic                        coin_reject, err;
  logic [1:0]                  err_code;
  logic                        led;

  modport master (
    output coin5, coin10, coin20, sel, qty, buy, cancel, admin_req, password,
           price_we, stock_we, cfg_data,
    input  credit, cost, price_rd, stock_rd, vend_valid, vend_type, vend_qty,
           chg20, chg10, chg5, coin_reject, err, err_code, led
  );

  modport slave (
    input  coin5, coin10, coin20, sel, qty, buy, cancel, admin_req, password,
           price_we, stock_we, cfg_data,
    output credit, cost, price_rd, stock_rd, vend_valid, vend_type, vend_qty,
           chg20, chg10, chg5, coin_reject, err, err_code, led
  );
endinterface

// File: rtl/ticket_vend_core.sv
// Ticket vending controller: coin credit, multi-quantity vend, greedy
// change return, idle timeout refund and password-gated price/stock edit.
// Money is in 5 Tk units.
module ticket_vend_core #(
  parameter int         NUM_TYPES   = 3,
  parameter int         SEL_W       = 2,
  parameter int         QTY_W       = 3,
  parameter int         PRICE_W     = 4,
  parameter int         STOCK_W     = 4,
  parameter int         CREDIT_W    = 6,
  parameter int         PRICE_INIT  = 2,
  parameter int         STOCK_INIT  = 7,
  parameter logic [3:0] PASSWORD    = 4'b1010,
  parameter int         TIMEOUT_CYC = 1000
) (
  input logic          clk,
  input logic          reset,
  ticket_vend_if.slave bus
);
  localparam int COST_W = PRICE_W + QTY_W;
  localparam int CMP_W  = PRICE_W + QTY_W + CREDIT_W + STOCK_W;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CREDIT, S_VEND, S_REFUND, S_ADMIN} state_t;

  state_t              r_state, w_nxt;
  logic [PRICE_W-1:0]  r_price [NUM_TYPES];
  logic [STOCK_W-1:0]  r_stock [NUM_TYPES];
  logic [CREDIT_W-1:0] r_credit, r_vcost;
  logic [TMO_W-1:0]    r_tmo;
  logic [SEL_W-1:0]    r_vtype;
  logic [QTY_W-1:0]    r_vqty;
  logic                r_rej, r_err;
  logic [1:0]          r_ecode;

  logic                w_sel_ok, w_any, w_ovf, w_qty_bad, w_funds_bad;
  logic [SEL_W-1:0]    w_idx;
  logic [PRICE_W-1:0]  w_price;
  logic [STOCK_W-1:0]  w_stock;
  logic [COST_W-1:0]   w_cost;
  logic [2:0]          w_inc;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_chg_amt, w_ref_left, w_vend_left;
  logic                w_add, w_rej, w_err, w_buy_go, w_tmo_clr, w_tmo_inc, w_cfg_wr;
  logic [1:0]          w_ecode;

  // Out-of-range selects read as zero so cost/price/stock stay defined.
  assign w_sel_ok    = (32'(bus.sel) < NUM_TYPES);
  assign w_idx       = w_sel_ok ? bus.sel : '0;
  assign w_price     = w_sel_ok ? r_price[w_idx] : '0;
  assign w_stock     = w_sel_ok ? r_stock[w_idx] : '0;
  assign w_cost      = COST_W'(w_price) * COST_W'(bus.qty);
  // Coin weights 1/2/4 line up with bit positions, so the sum is a concat.
  assign w_inc       = {bus.coin20, bus.coin10, bus.coin5};
  assign w_any       = |w_inc;
  assign w_sum       = (CREDIT_W+1)'(r_credit) + (CREDIT_W+1)'(w_inc);
  assign w_ovf       = w_sum[CREDIT_W];
  assign w_qty_bad   = (bus.qty == '0) || (CMP_W'(bus.qty) > CMP_W'(w_stock));
  assign w_funds_bad = CMP_W'(w_cost) > CMP_W'(r_credit);
  assign w_vend_left = r_credit - r_vcost;
  assign w_ref_left  = r_credit - w_chg_amt;

  // Largest change coin that fits in the remaining credit.
  always_comb begin
    w_chg_amt = '0;
    if (r_credit >= CREDIT_W'(4))      w_chg_amt = CREDIT_W'(4);
    else if (r_credit >= CREDIT_W'(2)) w_chg_amt = CREDIT_W'(2);
    else if (r_credit != '0)           w_chg_amt = CREDIT_W'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next state and datapath strobes; CREDIT priority is cancel > buy > coin.
  always_comb begin
    w_nxt     = r_state;
    w_add     = 1'b0;
    w_rej     = 1'b0;
    w_err     = 1'b0;
    w_ecode   = r_ecode;
    w_buy_go  = 1'b0;
    w_tmo_clr = 1'b0;
    w_tmo_inc = 1'b0;
    w_cfg_wr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.admin_req && bus.password == PASSWORD) begin
          w_nxt = S_ADMIN;
          w_rej = w_any;
        end else begin
          if (bus.admin_req) begin
            w_err   = 1'b1;
            w_ecode = 2'd3;
          end
          if (w_any && w_ovf) w_rej = 1'b1;
          else if (w_any) begin
            w_add     = 1'b1;
            w_tmo_clr = 1'b1;
            w_nxt     = S_CREDIT;
          end
        end
      end
      S_CREDIT: begin
        if (bus.cancel) begin
          w_rej = w_any;
          w_nxt = S_REFUND;
        end else if (bus.buy) begin
          w_rej     = w_any;
          w_tmo_clr = 1'b1;
          if (!w_sel_ok)        begin w_err = 1'b1; w_ecode = 2'd0; end
          else if (w_qty_bad)   begin w_err = 1'b1; w_ecode = 2'd1; end
          else if (w_funds_bad) begin w_err = 1'b1; w_ecode = 2'd2; end
          else begin
            w_buy_go = 1'b1;
            w_nxt    = S_VEND;
          end
        end else if (w_any && !w_ovf) begin
          w_add     = 1'b1;
          w_tmo_clr = 1'b1;
        end else begin
          w_rej = w_any;
          if (r_tmo == TMO_W'(TIMEOUT_CYC-1)) w_nxt = S_REFUND;
          else                                w_tmo_inc = 1'b1;
        end
      end
      S_VEND: begin
        w_rej = w_any;
        w_nxt = (w_vend_left != '0) ? S_REFUND : S_IDLE;
      end
      S_REFUND: begin
        w_rej = w_any;
        if (w_ref_left == '0) w_nxt = S_IDLE;
      end
      S_ADMIN: begin
        w_rej    = w_any;
        w_cfg_wr = w_sel_ok;
        if ((bus.price_we || bus.stock_we) && !w_sel_ok) begin
          w_err   = 1'b1;
          w_ecode = 2'd0;
        end
        if (bus.admin_req) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Credit, price/stock tables, vend capture and registered status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credit <= '0;
      r_vcost  <= '0;
      r_vtype  <= '0;
      r_vqty   <= '0;
      r_rej    <= 1'b0;
      r_err    <= 1'b0;
      r_ecode  <= 2'd0;
      for (int i = 0; i < NUM_TYPES; i++) begin
        r_price[i] <= PRICE_W'(PRICE_INIT);
        r_stock[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      r_rej   <= w_rej;
      r_err   <= w_err;
      r_ecode <= w_ecode;
      if (w_add)                  r_credit <= w_sum[CREDIT_W-1:0];
      else if (r_state == S_VEND) r_credit <= w_vend_left;
      else if (r_state == S_REFUND) r_credit <= w_ref_left;
      if (w_buy_go) begin
        r_vtype <= bus.sel;
        r_vqty  <= bus.qty;
        r_vcost <= CREDIT_W'(w_cost);
      end
      if (r_state == S_VEND) r_stock[r_vtype] <= r_stock[r_vtype] - STOCK_W'(r_vqty);
      if (w_cfg_wr && bus.price_we) r_price[w_idx] <= bus.cfg_data[PRICE_W-1:0];
      if (w_cfg_wr && bus.stock_we) r_stock[w_idx] <= bus.cfg_data[STOCK_W-1:0];
    end
  end

  // Idle counter only runs while holding credit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               r_tmo <= '0;
    else if (r_state != S_CREDIT || w_tmo_clr) r_tmo <= '0;
    else if (w_tmo_inc)                       r_tmo <= r_tmo + TMO_W'(1);
  end

  assign bus.credit      = r_credit;
  assign bus.cost        = w_cost;
  assign bus.price_rd    = w_price;
  assign bus.stock_rd    = w_stock;
  assign bus.vend_valid  = (r_state == S_VEND);
  assign bus.vend_type   = r_vtype;
  assign bus.vend_qty    = r_vqty;
  assign bus.chg20       = (r_state == S_REFUND) && (w_chg_amt == CREDIT_W'(4));
  assign bus.chg10       = (r_state == S_REFUND) && (w_chg_amt == CREDIT_W'(2));
  assign bus.chg5        = (r_state == S_REFUND) && (w_chg_amt == CREDIT_W'(1));
  assign bus.coin_reject = r_rej;
  assign bus.err         = r_err;
  assign bus.err_code    = r_ecode;
  assign bus.led         = (r_state == S_ADMIN);
endmodule

// File: tb/tb_ticket_vend_core.sv
// Bench for ticket_vend_core: directed scenarios with literal checks, plus a
// transaction-level model (credit/stock/price tables and a queue of change
// coins) compared against every output on each falling clock edge.
module tb_ticket_vend_core;
  localparam int NT  = 3;
  localparam int TMO = 1000;
  localparam int MAXC = 63;
  localparam int M_IDLE = 0, M_CREDIT = 1, M_VEND = 2, M_REFUND = 3, M_ADMIN = 4;
  localparam logic [5:0] C5 = 6'b000001, C10 = 6'b000010, C20 = 6'b000100,
                         BUY = 6'b001000, CAN = 6'b010000, ADM = 6'b100000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0, fails = 0;
  int n20 = 0, n10 = 0, n5 = 0;

  ticket_vend_if bus();
  ticket_vend_core dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int m_st, m_credit, m_vt, m_vq, m_ecode;
  int m_price[NT], m_stock[NT];
  bit m_rej, m_err;
  int chg_q[$];

  task automatic mreset();
    m_st = M_IDLE; m_credit = 0; m_vt = 0; m_vq = 0; m_ecode = 0;
    m_rej = 0; m_err = 0; chg_q.delete();
    for (int i = 0; i < NT; i++) begin m_price[i] = 2; m_stock[i] = 7; end
  endtask

  // Change is paid greedily: as many 20s as fit, then at most one 10 and one 5.
  task automatic go_refund();
    int c;
    c = m_credit;
    chg_q.delete();
    while (c >= 4) begin chg_q.push_back(4); c -= 4; end
    if (c >= 2) begin chg_q.push_back(2); c -= 2; end
    if (c >= 1) chg_q.push_back(1);
    m_st = (chg_q.size() > 0) ? M_REFUND : M_IDLE;
  endtask

  int m_idle = 0;
  task automatic mstep();
    int inc, s, q;
    bit anyc, rej, er;
    inc  = int'(bus.coin5) + 2*int'(bus.coin10) + 4*int'(bus.coin20);
    anyc = (inc != 0);
    s = int'(bus.sel); q = int'(bus.qty);
    rej = 0; er = 0;
    case (m_st)
      M_IDLE: begin
        if (bus.admin_req && bus.password == 4'b1010) begin m_st = M_ADMIN; rej = anyc; end
        else begin
          if (bus.admin_req) begin er = 1; m_ecode = 3; end
          if (anyc) begin
            if (m_credit + inc > MAXC) rej = 1;
            else begin m_credit += inc; m_st = M_CREDIT; m_idle = 0; end
          end
        end
      end
      M_CREDIT: begin
        if (bus.cancel) begin rej = anyc; go_refund(); end
        else if (bus.buy) begin
          rej = anyc; m_idle = 0;
          if (s >= NT) begin er = 1; m_ecode = 0; end
          else if (q == 0 || q > m_stock[s]) begin er = 1; m_ecode = 1; end
          else if (m_price[s] * q > m_credit) begin er = 1; m_ecode = 2; end
          else begin m_vt = s; m_vq = q; m_st = M_VEND; end
        end else if (anyc && m_credit + inc <= MAXC) begin m_credit += inc; m_idle = 0; end
        else begin
          rej = anyc;
          if (m_idle == TMO-1) go_refund(); else m_idle++;
        end
      end
      M_VEND: begin
        rej = anyc;
        m_stock[m_vt] -= m_vq;
        m_credit -= m_price[m_vt] * m_vq;
        go_refund();
      end
      M_REFUND: begin
        rej = anyc;
        m_credit -= chg_q.pop_front();
        if (chg_q.size() == 0) m_st = M_IDLE;
      end
      M_ADMIN: begin
        rej = anyc;
        if (bus.price_we || bus.stock_we) begin
          if (s < NT) begin
            if (bus.price_we) m_price[s] = int'(bus.cfg_data);
            if (bus.stock_we) m_stock[s] = int'(bus.cfg_data);
          end else begin er = 1; m_ecode = 0; end
        end
        if (bus.admin_req) m_st = M_IDLE;
      end
      default: m_st = M_IDLE;
    endcase
    m_rej = rej; m_err = er;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) mreset(); else mstep();
    end
  end

  // Compare every output against the model, away from the active edge.
  initial begin
    int s, ep, es, c;
    #3;
    forever begin
      @(negedge clk);
      s  = int'(bus.sel);
      ep = (s < NT) ? m_price[s] : 0;
      es = (s < NT) ? m_stock[s] : 0;
      c  = (m_st == M_REFUND && chg_q.size() > 0) ? chg_q[0] : 0;
      chk("m_credit",   32'(bus.credit),      m_credit);
      chk("m_price_rd", 32'(bus.price_rd),    ep);
      chk("m_stock_rd", 32'(bus.stock_rd),    es);
      chk("m_cost",     32'(bus.cost),        ep * int'(bus.qty));
      chk("m_vend",     32'(bus.vend_valid),  (m_st == M_VEND) ? 1 : 0);
      if (m_st == M_VEND) begin
        chk("m_vtype", 32'(bus.vend_type), m_vt);
        chk("m_vqty",  32'(bus.vend_qty),  m_vq);
      end
      chk("m_chg20",    32'(bus.chg20),       (c == 4) ? 1 : 0);
      chk("m_chg10",    32'(bus.chg10),       (c == 2) ? 1 : 0);
      chk("m_chg5",     32'(bus.chg5),        (c == 1) ? 1 : 0);
      chk("m_reject",   32'(bus.coin_reject), m_rej ? 1 : 0);
      chk("m_err",      32'(bus.err),         m_err ? 1 : 0);
      chk("m_err_code", 32'(bus.err_code),    m_ecode);
      chk("m_led",      32'(bus.led),         (m_st == M_ADMIN) ? 1 : 0);
      if (bus.chg20) n20++;
      if (bus.chg10) n10++;
      if (bus.chg5)  n5++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // p = {admin_req, cancel, buy, coin20, coin10, coin5}, held for one cycle.
  task automatic cyc(input logic [5:0] p);
    {bus.admin_req, bus.cancel, bus.buy, bus.coin20, bus.coin10, bus.coin5} = p;
    @(posedge clk); #1;
    {bus.admin_req, bus.cancel, bus.buy, bus.coin20, bus.coin10, bus.coin5} = 6'b0;
  endtask

  task automatic clr_cnt();
    n20 = 0; n10 = 0; n5 = 0;
  endtask

  initial begin
    {bus.admin_req, bus.cancel, bus.buy, bus.coin20, bus.coin10, bus.coin5} = 6'b0;
    bus.sel = 2'd0; bus.qty = 3'd0; bus.password = 4'd0;
    bus.price_we = 1'b0; bus.stock_we = 1'b0; bus.cfg_data = 4'd0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_credit", 32'(bus.credit),   0);
    chk("rst_led",    32'(bus.led),      0);
    chk("rst_price",  32'(bus.price_rd), 2);
    chk("rst_stock",  32'(bus.stock_rd), 7);
    chk("rst_ecode",  32'(bus.err_code), 0);
    reset = 1'b1;
    idle(1);

    // 20 + 10 -> 6, buy 2 of type 1 at 2 each -> vend, change 10 Tk.
    cyc(C20); cyc(C10);
    chk("A_credit", 32'(bus.credit), 6);
    bus.sel = 2'd1; bus.qty = 3'd2;
    cyc(BUY);
    chk("A_vend",  32'(bus.vend_valid), 1);
    chk("A_vtype", 32'(bus.vend_type),  1);
    chk("A_vqty",  32'(bus.vend_qty),   2);
    clr_cnt();
    idle(1);
    chk("A_chg10", 32'(bus.chg10), 1);
    idle(2);
    chk("A_credit0", 32'(bus.credit),   0);
    chk("A_stock1",  32'(bus.stock_rd), 5);
    chk("A_n10", 32'(n10), 1); chk("A_n20", 32'(n20), 0); chk("A_n5", 32'(n5), 0);

    // Insufficient funds: credit 2, cost 4.
    cyc(C10);
    bus.sel = 2'd0; bus.qty = 3'd2;
    cyc(BUY);
    chk("B_err",    32'(bus.err),      1);
    chk("B_ecode",  32'(bus.err_code), 2);
    chk("B_credit", 32'(bus.credit),   2);
    chk("B_stock",  32'(bus.stock_rd), 7);
    cyc(CAN); idle(3);

    // Fill to 62, overflow coin rejected, then full refund.
    repeat (15) cyc(C20);
    cyc(C10);
    chk("C_credit62", 32'(bus.credit), 62);
    cyc(C20);
    chk("C_reject", 32'(bus.coin_reject), 1);
    chk("C_hold62", 32'(bus.credit),      62);
    clr_cnt();
    cyc(CAN); idle(20);
    chk("C_n20", 32'(n20), 15); chk("C_n10", 32'(n10), 1); chk("C_n5", 32'(n5), 0);
    chk("C_credit0", 32'(bus.credit), 0);

    // Two coins in one cycle (3), then idle timeout.
    cyc(C5 | C10);
    chk("T_credit3", 32'(bus.credit), 3);
    clr_cnt();
    idle(TMO-1);
    chk("T_before",  32'(bus.chg10),  0);
    chk("T_hold3",   32'(bus.credit), 3);
    idle(1);
    chk("T_chg10", 32'(bus.chg10), 1);
    idle(1);
    chk("T_chg5", 32'(bus.chg5), 1);
    idle(1);
    chk("T_credit0", 32'(bus.credit), 0);
    chk("T_n10", 32'(n10), 1); chk("T_n5", 32'(n5), 1);

    // Admin: wrong password, unlock, price edit, bad-sel write, exit.
    bus.password = 4'b0101;
    cyc(ADM);
    chk("D_err",   32'(bus.err),      1);
    chk("D_ecode", 32'(bus.err_code), 3);
    chk("D_led0",  32'(bus.led),      0);
    bus.password = 4'b1010;
    cyc(ADM);
    chk("D_led1", 32'(bus.led), 1);
    bus.sel = 2'd2; bus.cfg_data = 4'd5; bus.price_we = 1'b1;
    idle(1);
    bus.price_we = 1'b0;
    chk("D_price5", 32'(bus.price_rd), 5);
    cyc(C5);
    chk("D_coinrej", 32'(bus.coin_reject), 1);
    bus.sel = 2'd3; bus.stock_we = 1'b1;
    idle(1);
    bus.stock_we = 1'b0;
    chk("D_selerr",   32'(bus.err),      1);
    chk("D_selecode", 32'(bus.err_code), 0);
    cyc(ADM);
    chk("D_ledoff", 32'(bus.led), 0);
    bus.sel = 2'd2; bus.qty = 3'd2;
    #1 chk("D_cost10", 32'(bus.cost), 10);

    // Buy errors: bad select, zero qty, qty > stock, funds.
    cyc(C5);
    bus.sel = 2'd3; bus.qty = 3'd1; cyc(BUY);
    chk("E_sel", 32'(bus.err_code), 0);
    bus.sel = 2'd1; bus.qty = 3'd0; cyc(BUY);
    chk("E_qty0", 32'(bus.err_code), 1);
    bus.qty = 3'd6; cyc(BUY);
    chk("E_qtybig_err", 32'(bus.err), 1);
    chk("E_qtybig",     32'(bus.err_code), 1);
    bus.qty = 3'd5; cyc(BUY);
    chk("E_funds", 32'(bus.err_code), 2);
    cyc(CAN); idle(3);

    // Exact payment: no change; coins during buy and VEND are refused.
    bus.sel = 2'd0; bus.qty = 3'd2;
    cyc(C20);
    cyc(BUY | C5);
    chk("F_vend", 32'(bus.vend_valid),  1);
    chk("F_rej",  32'(bus.coin_reject), 1);
    cyc(C10);
    chk("F_rej2",    32'(bus.coin_reject), 1);
    chk("F_credit0", 32'(bus.credit),      0);
    chk("F_stock",   32'(bus.stock_rd),    5);

    // Reset in the middle of a refund.
    bus.sel = 2'd1;
    cyc(C20); cyc(C20); cyc(CAN);
    chk("R_chg20", 32'(bus.chg20), 1);
    idle(1);
    chk("R_credit4", 32'(bus.credit), 4);
    reset = 1'b0;
    #1;
    chk("R_credit", 32'(bus.credit),   0);
    chk("R_chg",    32'(bus.chg20),    0);
    chk("R_stock",  32'(bus.stock_rd), 7);
    chk("R_ecode",  32'(bus.err_code), 0);
    chk("R_led",    32'(bus.led),      0);
    bus.sel = 2'd2;
    #1 chk("R_price", 32'(bus.price_rd), 2);
    @(posedge clk); #1 reset = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
